// File: rtl/pkt_bufid_refcnt_manage_pkg.sv
// Shared constants and types for the buffer-ID lifetime manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_bufid_refcnt_manage_pkg;

    localparam int BUFID_W  = 9;
    localparam int BUF_NUM  = 512;
    localparam int CNT_W    = 4;
    localparam int PORT_NUM = 5;
    localparam int FCNT_W   = 10;
    localparam int PTR_W    = 3;

    // Release requester indices
    localparam int P0   = 0;
    localparam int P1   = 1;
    localparam int P2   = 2;
    localparam int P3   = 3;
    localparam int HOST = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

    typedef enum logic [1:0] {
        PUSH_NONE = 2'd0,
        PUSH_INIT = 2'd1,
        PUSH_SET  = 2'd2,
        PUSH_REL  = 2'd3
    } push_src_e;

    // Reduce a small sum of requester indices back into 0..PORT_NUM-1
    function automatic logic [PTR_W-1:0] rr_wrap(input logic [3:0] v);
        return (v >= 4'(PORT_NUM)) ? PTR_W'(v - 4'(PORT_NUM)) : v[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/pkt_bufid_refcnt_manage_fifo.sv
// Free-list FIFO: 512 x 9 show-ahead queue over a simple dual-port RAM, with occupancy count.
// Latency: a pushed ID reaches the head 2 cycles after its push cycle; count updates on the next edge.
// Backpressure: none; pop is ignored while the head is empty, overflow cannot occur (IDs are unique).
module bufid_free_fifo
    import pkt_bufid_refcnt_manage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_vld,
    input  logic [BUFID_W-1:0] push_dat,
    input  logic               pop_vld,
    output logic [BUFID_W-1:0] head_dat,
    output logic               head_vld,
    output logic [FCNT_W-1:0]  cnt
);

    logic [BUFID_W-1:0] mem [BUF_NUM];
    logic [BUFID_W-1:0] wr_ptr;
    logic [BUFID_W-1:0] rd_ptr;
    logic [FCNT_W-1:0]  ram_cnt;
    logic               pop_ok;
    logic               fetch;

    // Only entries written on an earlier edge are fetched, so no read/write collision exists.
    assign pop_ok = pop_vld & head_vld;
    assign fetch  = (ram_cnt != '0) && (!head_vld || pop_ok);

    // RAM write port; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Registered RAM read refills the head register whenever it is empty or being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            head_dat <= '0;
            head_vld <= 1'b0;
        end else if (fetch) begin
            head_dat <= mem[rd_ptr];
            head_vld <= 1'b1;
            rd_ptr   <= rd_ptr + BUFID_W'(1);
        end else if (pop_ok) begin
            head_vld <= 1'b0;
        end
    end

    // Write pointer, RAM-resident count and total (head included) count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            ram_cnt <= '0;
            cnt     <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + BUFID_W'(1);
            end
            ram_cnt <= ram_cnt + FCNT_W'(push_vld) - FCNT_W'(fetch);
            cnt     <= cnt + FCNT_W'(push_vld) - FCNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/pkt_bufid_refcnt_manage.sv
// Buffer-ID lifetime manager: per-ID reference counters, 5-way RR release arbiter, free-list feed.
// Latency: counters update at the end of the set/grant cycle; freed ID at head >= 2 cycles later.
// Backpressure: release requests hold until ack; no release grant in a cycle with a zero-count set.
module pkt_bufid_refcnt_manage
    import pkt_bufid_refcnt_manage_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BUFID_W-1:0] iv_pkt_bufid,
    input  logic               i_pkt_bufid_wr,
    input  logic [CNT_W-1:0]   iv_pkt_bufid_cnt,
    input  logic [BUFID_W-1:0] iv_release_bufid_p0,
    input  logic [BUFID_W-1:0] iv_release_bufid_p1,
    input  logic [BUFID_W-1:0] iv_release_bufid_p2,
    input  logic [BUFID_W-1:0] iv_release_bufid_p3,
    input  logic [BUFID_W-1:0] iv_release_bufid_host,
    input  logic               i_release_wr_p0,
    input  logic               i_release_wr_p1,
    input  logic               i_release_wr_p2,
    input  logic               i_release_wr_p3,
    input  logic               i_release_wr_host,
    output logic               o_release_ack_p0,
    output logic               o_release_ack_p1,
    output logic               o_release_ack_p2,
    output logic               o_release_ack_p3,
    output logic               o_release_ack_host,
    output logic [BUFID_W-1:0] ov_alloc_bufid,
    output logic               o_alloc_bufid_valid,
    input  logic               i_alloc_bufid_rd,
    output logic [FCNT_W-1:0]  ov_free_cnt,
    output logic               o_init_done,
    output logic               o_refcnt_err
);

    init_state_e        state_q;
    init_state_e        state_d;
    logic               init_push;
    logic               init_done;
    logic [BUFID_W-1:0] init_cnt;

    logic [CNT_W-1:0]   refcnt [BUF_NUM];

    logic               set_wr;
    logic               set_zero;
    logic               set_nz;

    logic [PORT_NUM-1:0] req;
    logic [BUFID_W-1:0]  rel_id [PORT_NUM];
    logic                arb_en;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    cand;
    logic                gnt_vld;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PORT_NUM-1:0] gnt_vec;
    logic [PORT_NUM-1:0] ack;

    logic [BUFID_W-1:0] rel_bufid;
    logic [CNT_W-1:0]   rel_cur;
    logic [CNT_W-1:0]   rel_eff;
    logic [CNT_W-1:0]   rel_dec;
    logic               rel_zero;
    logic               rel_last;

    push_src_e          push_src;
    logic               push_vld;
    logic [BUFID_W-1:0] push_dat;
    logic               pop_vld;
    logic               head_vld;
    logic               err_d;

    assign init_done   = (state_q == ST_RUN);
    assign o_init_done = init_done;

    // Init state register: fill the free list once after every reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Push one ID per cycle while filling; leave after ID BUF_NUM-1 is pushed.
    always_comb begin
        state_d   = state_q;
        init_push = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_push = 1'b1;
                if (init_cnt == BUFID_W'(BUF_NUM - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Init ID counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            init_cnt <= '0;
        end else if (init_push) begin
            init_cnt <= init_cnt + BUFID_W'(1);
        end
    end

    // Forward-count strobe is only acted on once the free list is ready.
    assign set_wr   = i_pkt_bufid_wr & init_done;
    assign set_zero = set_wr & (iv_pkt_bufid_cnt == '0);
    assign set_nz   = set_wr & (iv_pkt_bufid_cnt != '0);

    assign req[P0]      = i_release_wr_p0;
    assign req[P1]      = i_release_wr_p1;
    assign req[P2]      = i_release_wr_p2;
    assign req[P3]      = i_release_wr_p3;
    assign req[HOST]    = i_release_wr_host;
    assign rel_id[P0]   = iv_release_bufid_p0;
    assign rel_id[P1]   = iv_release_bufid_p1;
    assign rel_id[P2]   = iv_release_bufid_p2;
    assign rel_id[P3]   = iv_release_bufid_p3;
    assign rel_id[HOST] = iv_release_bufid_host;

    // A zero-count set owns the single push port, so releases wait that cycle.
    assign arb_en = init_done & ~set_zero & ~i_rst;

    // Round-robin search starting at rr_ptr; first active requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        cand    = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            cand = rr_wrap({1'b0, rr_ptr} + 4'(k));
            if (arb_en && !gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vec[gnt_idx] = gnt_vld;
    end

    assign ack                = req & gnt_vec;
    assign o_release_ack_p0   = ack[P0];
    assign o_release_ack_p1   = ack[P1];
    assign o_release_ack_p2   = ack[P2];
    assign o_release_ack_p3   = ack[P3];
    assign o_release_ack_host = ack[HOST];

    // A same-cycle set to the released ID is applied first, then decremented.
    assign rel_bufid = rel_id[gnt_idx];
    assign rel_cur   = refcnt[rel_bufid];
    assign rel_eff   = (set_nz && (iv_pkt_bufid == rel_bufid)) ? iv_pkt_bufid_cnt : rel_cur;
    assign rel_dec   = rel_eff - CNT_W'(1);
    assign rel_zero  = gnt_vld & (rel_eff == '0);
    assign rel_last  = gnt_vld & (rel_eff == CNT_W'(1));

    // Push source select; the sources are mutually exclusive by construction.
    always_comb begin
        push_src = PUSH_NONE;
        push_dat = '0;
        if (!init_done) begin
            push_src = PUSH_INIT;
            push_dat = init_cnt;
        end else if (set_zero) begin
            push_src = PUSH_SET;
            push_dat = iv_pkt_bufid;
        end else if (rel_last) begin
            push_src = PUSH_REL;
            push_dat = rel_bufid;
        end
    end

    assign push_vld = (push_src != PUSH_NONE) & ~i_rst;

    // Protocol violations: strobe during init, set over a live count, release of a free ID.
    assign err_d = (i_pkt_bufid_wr & ~init_done)
                 | (set_nz & (refcnt[iv_pkt_bufid] != '0))
                 | rel_zero;

    // Reference counters: set first, release result overrides on the same index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_NUM; i++) begin
                refcnt[i] <= '0;
            end
        end else begin
            if (set_nz) begin
                refcnt[iv_pkt_bufid] <= iv_pkt_bufid_cnt;
            end
            if (gnt_vld && (rel_eff != '0)) begin
                refcnt[rel_bufid] <= rel_dec;
            end
        end
    end

    // Arbiter pointer and registered error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr       <= '0;
            o_refcnt_err <= 1'b0;
        end else begin
            o_refcnt_err <= err_d;
            if (gnt_vld) begin
                rr_ptr <= rr_wrap({1'b0, gnt_idx} + 4'd1);
            end
        end
    end

    assign o_alloc_bufid_valid = head_vld & init_done;
    assign pop_vld             = i_alloc_bufid_rd & o_alloc_bufid_valid & ~i_rst;

    bufid_free_fifo u_free_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (ov_alloc_bufid),
        .head_vld (head_vld),
        .cnt      (ov_free_cnt)
    );

endmodule
